// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: widths, reset PC, halt opcode,
// FSM state encoding and the next-PC select used by the PC register.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_STEP  = 16'd2;
  localparam logic [3:0]        OPC_HALT = 4'hF;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  // Opcode field lives in the top nibble of every instruction.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[15:12] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with its next-PC mux (hold / step / redirect).
// The redirect target always has bit 0 cleared so the PC stays even.
module fetch_pc_reg
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           pc_sel,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next-PC selection; increment wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:   pc_d = pc_q + PC_STEP;
      PC_REDIR: pc_d = redirect_pc & {{(ADDR_W-1){1'b1}}, 1'b0};
      default:  pc_d = pc_q;
    endcase
  end

  // PC register, asynchronously reset to the boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives instr_mem address, captures the returned
// word into the IR and offers it to decode.
// Handshake: decode takes the IR on any rising edge where ir_valid && ir_ready
// are both high; ir_valid never drops without a transfer except on a redirect
// (squash) or reset, and IR contents are stable while ir_valid && !ir_ready.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               resume,
  output logic               halted,
  output fetch_state_e       state_dbg
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  pc_sel_e            pc_sel;
  logic               slot_free;

  fetch_pc_reg u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc_out)
  );

  // IR may be loaded when empty or when decode drains it this cycle.
  assign slot_free = !ir_valid_q || ir_ready;

  // Next-state and IR control; redirect beats resume beats normal fetch.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_sel     = PC_HOLD;
    if (redirect_valid) begin
      pc_sel     = PC_REDIR;
      ir_valid_d = 1'b0;
      state_d    = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (slot_free) begin
            ir_d       = instr_in;
            ir_pc_d    = pc_out;
            ir_valid_d = 1'b1;
            pc_sel     = PC_INC;
            if (is_halt(instr_in)) state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          // The halt instruction itself still drains to decode.
          if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
          if (resume) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Stage registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [15:0]        pc_out;
  logic [15:0]        instr_in;
  logic               ir_valid;
  logic [15:0]        ir;
  logic [15:0]        ir_pc;
  logic               ir_ready = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [15:0]        redirect_pc = 16'h0000;
  logic               resume = 1'b0;
  logic               halted;
  fetch_state_e       state_dbg;

  logic [15:0] mem [0:32767];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign instr_in = mem[pc_out[15:1]];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resume         (resume),
    .halted         (halted),
    .state_dbg      (state_dbg)
  );

  // Default memory image: word at byte address a is {4'h1, a[12:1]}.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    return {4'h1, a[12:1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ir_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc_out !== 16'h0000 || ir_valid !== 1'b0 || ir !== 16'h0000 ||
        ir_pc !== 16'h0000 || halted !== 1'b0 || state_dbg !== ST_FETCH) begin
      errors++;
      $display("FAIL reset: pc_out=%h ir_valid=%b ir=%h ir_pc=%h halted=%b state=%0d expected 0000 0 0000 0000 0 0",
               pc_out, ir_valid, ir, ir_pc, halted, state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      a = 16'(2 * k);
      step();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== a || ir !== word_at(a) || pc_out !== a + 16'd2) begin
        errors++;
        $display("FAIL seq[%0d]: ir_valid=%b ir_pc=%h ir=%h pc_out=%h expected 1 %h %h %h",
                 k, ir_valid, ir_pc, ir, pc_out, a, word_at(a), a + 16'd2);
      end
    end
  endtask

  task automatic test_stall();
    ir_ready = 1'b1;
    do_redirect(16'h0000);
    repeat (3) step();   // ir_pc 0000, 0002, 0004
    checks++;
    if (ir_pc !== 16'h0004 || pc_out !== 16'h0006) begin
      errors++;
      $display("FAIL stall_setup: ir_pc=%h pc_out=%h expected 0004 0006", ir_pc, pc_out);
    end
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 16'h0004 || ir !== word_at(16'h0004) || pc_out !== 16'h0006) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ir_valid=%b ir_pc=%h ir=%h pc_out=%h expected 1 0004 %h 0006",
                 k, ir_valid, ir_pc, ir, pc_out, word_at(16'h0004));
      end
    end
    ir_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [15:0] a;
      a = 16'(6 + 2 * k);
      step();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== a || ir !== word_at(a) || pc_out !== a + 16'd2) begin
        errors++;
        $display("FAIL stall_resume[%0d]: ir_valid=%b ir_pc=%h ir=%h pc_out=%h expected 1 %h %h %h",
                 k, ir_valid, ir_pc, ir, pc_out, a, word_at(a), a + 16'd2);
      end
    end
  endtask

  task automatic test_redirect();
    ir_ready = 1'b1;
    do_redirect(16'h0021);
    checks++;
    if (pc_out !== 16'h0020 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_squash: pc_out=%h ir_valid=%b expected 0020 0", pc_out, ir_valid);
    end
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 16'h0020 || ir !== word_at(16'h0020) || pc_out !== 16'h0022) begin
      errors++;
      $display("FAIL redirect_target: ir_valid=%b ir_pc=%h ir=%h pc_out=%h expected 1 0020 %h 0022",
               ir_valid, ir_pc, ir, pc_out, word_at(16'h0020));
    end
  endtask

  task automatic test_halt();
    mem[5] = 16'hF000;   // byte address 000A
    ir_ready = 1'b1;
    do_redirect(16'h0008);
    step();              // ir_pc 0008
    step();              // ir_pc 000A (halt)
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 16'h000A || ir !== 16'hF000 || pc_out !== 16'h000C ||
        halted !== 1'b1 || state_dbg !== ST_HALT) begin
      errors++;
      $display("FAIL halt_capture: ir_valid=%b ir_pc=%h ir=%h pc_out=%h halted=%b expected 1 000A F000 000C 1",
               ir_valid, ir_pc, ir, pc_out, halted);
    end
    ir_ready = 1'b0;
    step();
    checks++;
    if (ir_valid !== 1'b1 || pc_out !== 16'h000C || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_wait: ir_valid=%b pc_out=%h halted=%b expected 1 000C 1", ir_valid, pc_out, halted);
    end
    ir_ready = 1'b1;
    repeat (2) step();
    checks++;
    if (ir_valid !== 1'b0 || ir !== 16'hF000 || ir_pc !== 16'h000A || pc_out !== 16'h000C || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_drained: ir_valid=%b ir=%h ir_pc=%h pc_out=%h halted=%b expected 0 F000 000A 000C 1",
               ir_valid, ir, ir_pc, pc_out, halted);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || state_dbg !== ST_FETCH || pc_out !== 16'h000C || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume: halted=%b state=%0d pc_out=%h ir_valid=%b expected 0 0 000C 0",
               halted, state_dbg, pc_out, ir_valid);
    end
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 16'h000C || ir !== word_at(16'h000C) || pc_out !== 16'h000E) begin
      errors++;
      $display("FAIL resume_fetch: ir_valid=%b ir_pc=%h ir=%h pc_out=%h expected 1 000C %h 000E",
               ir_valid, ir_pc, ir, pc_out, word_at(16'h000C));
    end
    mem[5] = word_at(16'h000A);
  endtask

  task automatic test_wrap_and_async_reset();
    ir_ready = 1'b1;
    do_redirect(16'hFFFF);
    checks++;
    if (pc_out !== 16'hFFFE || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_redirect: pc_out=%h ir_valid=%b expected FFFE 0", pc_out, ir_valid);
    end
    step();
    checks++;
    if (ir_pc !== 16'hFFFE || ir !== word_at(16'hFFFE) || pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_top: ir_pc=%h ir=%h pc_out=%h expected FFFE %h 0000",
               ir_pc, ir, pc_out, word_at(16'hFFFE));
    end
    step();
    checks++;
    if (ir_pc !== 16'h0000 || ir !== word_at(16'h0000) || pc_out !== 16'h0002) begin
      errors++;
      $display("FAIL wrap_zero: ir_pc=%h ir=%h pc_out=%h expected 0000 %h 0002",
               ir_pc, ir, pc_out, word_at(16'h0000));
    end
    ir_ready = 1'b0;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc_out !== 16'h0000 || ir_valid !== 1'b0 || ir !== 16'h0000 || ir_pc !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc_out=%h ir_valid=%b ir=%h ir_pc=%h halted=%b expected 0000 0 0000 0000 0",
               pc_out, ir_valid, ir, ir_pc, halted);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = word_at(16'(2 * i));
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
